// File: rtl/ddr_train_mon_pkg.sv
// ddr_train_mon_pkg: shared encodings for the DDR training monitor
// (event types reported on the event stream, and the monitor FSM states).
package ddr_train_mon_pkg;

    localparam int EVT_TYPE_W = 2;

    // Event type carried on evt_type
    typedef enum logic [EVT_TYPE_W-1:0] {
        EVT_STAGE   = 2'd0,
        EVT_ERR     = 2'd1,
        EVT_TIMEOUT = 2'd2,
        EVT_START   = 2'd3
    } evt_type_e;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/train_mon_fifo.sv
// train_mon_fifo: small event FIFO with flop-based storage. Pointers carry one
// extra wrap bit to tell full from empty. A push while full is dropped and
// recorded in a sticky overflow flag; a pop in the same cycle does not make
// room. The head word reads as zero whenever the FIFO is empty.
module train_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             overflow_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance and sticky overflow capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];
    assign overflow  = overflow_reg;

endmodule

// File: rtl/ddr_train_monitor.sv
// ddr_train_monitor: times each sequential PHY training stage and reports
// START / STAGE / ERR / TIMEOUT events through a small FIFO, plus summary
// status (train_done, train_fail, fail_code).
// Build option: define DDR_TRAIN_MON_TIMEOUT_EN to enable the per-stage
// timeout of TIMEOUT_CYC cycles; without it a stage may wait forever.
module ddr_train_monitor
    import ddr_train_mon_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int ERR_W       = 8,
    parameter int CNT_W       = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4194304,
    localparam int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  phy_rst_n,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [ERR_W-1:0]      error_status,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [1:0]            evt_type,
    output logic [STG_W-1:0]      evt_stage,
    output logic [CNT_W-1:0]      evt_data,
    output logic [STG_W-1:0]      cur_stage,
    output logic                  train_done,
    output logic                  train_fail,
    output logic [ERR_W-1:0]      fail_code,
    output logic                  evt_overflow
);

    localparam int               EVT_W      = EVT_TYPE_W + STG_W + CNT_W;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_DATA   = CNT_W'(TIMEOUT_CYC);

    state_e           state_reg;
    logic [CNT_W-1:0] cyc_cnt_reg;
    logic [STG_W-1:0] cur_stage_reg;
    logic             train_done_reg;
    logic             train_fail_reg;
    logic [ERR_W-1:0] fail_code_reg;

    logic [CNT_W-1:0]      cnt_inc;
    logic [NUM_STAGES-1:0] stage_sel;
    logic                  stage_hit;
    logic                  err_hit;
    logic                  tmo_hit;

    logic             push_req;
    evt_type_e        push_type;
    logic [STG_W-1:0] push_stage;
    logic [CNT_W-1:0] push_data;

    logic             fifo_full;
    logic             fifo_empty;
    logic [EVT_W-1:0] fifo_head;

    // Saturating successor of the cycle counter (also the STAGE event data)
    assign cnt_inc = (cyc_cnt_reg == CNT_MAX) ? CNT_MAX : cyc_cnt_reg + 1'b1;

    // Only the done flag of the stage being timed counts
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_sel
            assign stage_sel[gi] = stage_done[gi] && (cur_stage_reg == STG_W'(gi));
        end
    endgenerate

    assign stage_hit = |stage_sel;
    assign err_hit   = |error_status;

`ifdef DDR_TRAIN_MON_TIMEOUT_EN
    assign tmo_hit = (cyc_cnt_reg == TMO_LAST);
`else
    logic unused_tmo;
    assign unused_tmo = ^{TMO_LAST, TMO_DATA};
    assign tmo_hit    = 1'b0;
`endif

    // Event decode: what (if anything) enters the FIFO at the end of this cycle
    always_comb begin
        push_req   = 1'b0;
        push_type  = EVT_START;
        push_stage = '0;
        push_data  = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (phy_rst_n) begin
                    push_req = 1'b1;
                end
            end
            ST_RUN: begin
                if (phy_rst_n) begin
                    if (err_hit) begin
                        push_req   = 1'b1;
                        push_type  = EVT_ERR;
                        push_stage = cur_stage_reg;
                        push_data  = CNT_W'(error_status);
                    end else if (stage_hit) begin
                        push_req   = 1'b1;
                        push_type  = EVT_STAGE;
                        push_stage = cur_stage_reg;
                        push_data  = cnt_inc;
                    end else if (tmo_hit) begin
                        push_req   = 1'b1;
                        push_type  = EVT_TIMEOUT;
                        push_stage = cur_stage_reg;
                        push_data  = TMO_DATA;
                    end
                end
            end
            default: ;
        endcase
    end

    // Training FSM with stage timer and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cyc_cnt_reg    <= '0;
            cur_stage_reg  <= '0;
            train_done_reg <= 1'b0;
            train_fail_reg <= 1'b0;
            fail_code_reg  <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (phy_rst_n) begin
                        state_reg     <= ST_RUN;
                        cyc_cnt_reg   <= '0;
                        cur_stage_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (!phy_rst_n) begin
                        state_reg      <= ST_IDLE;
                        cyc_cnt_reg    <= '0;
                        cur_stage_reg  <= '0;
                        train_done_reg <= 1'b0;
                        train_fail_reg <= 1'b0;
                        fail_code_reg  <= '0;
                    end else if (err_hit) begin
                        state_reg      <= ST_FAIL;
                        train_fail_reg <= 1'b1;
                        fail_code_reg  <= error_status;
                    end else if (stage_hit) begin
                        cyc_cnt_reg <= '0;
                        if (cur_stage_reg == LAST_STAGE) begin
                            state_reg      <= ST_DONE;
                            train_done_reg <= 1'b1;
                        end else begin
                            cur_stage_reg <= cur_stage_reg + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_reg      <= ST_FAIL;
                        train_fail_reg <= 1'b1;
                    end else begin
                        cyc_cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    // DONE and FAIL hold their status until the PHY is reset
                    if (!phy_rst_n) begin
                        state_reg      <= ST_IDLE;
                        cyc_cnt_reg    <= '0;
                        cur_stage_reg  <= '0;
                        train_done_reg <= 1'b0;
                        train_fail_reg <= 1'b0;
                        fail_code_reg  <= '0;
                    end
                end
            endcase
        end
    end

    train_mon_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data ({push_type, push_stage, push_data}),
        .pop       (evt_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head),
        .overflow  (evt_overflow)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_type   = fifo_head[EVT_W-1 -: EVT_TYPE_W];
    assign evt_stage  = fifo_head[CNT_W +: STG_W];
    assign evt_data   = fifo_head[CNT_W-1:0];
    assign cur_stage  = cur_stage_reg;
    assign train_done = train_done_reg;
    assign train_fail = train_fail_reg;
    assign fail_code  = fail_code_reg;

endmodule

// File: tb/tb_ddr_train_monitor.sv
// tb_ddr_train_monitor: randomized and directed training scenarios. Expected
// events are derived from stage-completion times with plain arithmetic and
// queued; a negedge monitor pops and compares every accepted event.
module tb_ddr_train_monitor;

    localparam int NS    = 5;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int INF   = 1000000;
    localparam logic [1:0] T_STAGE = 2'd0, T_ERR = 2'd1, T_TMO = 2'd2, T_START = 2'd3;

    typedef struct packed {
        logic [1:0]  typ;
        logic [2:0]  stg;
        logic [23:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phy_rst_n;
    logic [4:0]  stage_done;
    logic [7:0]  error_status;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_type;
    logic [2:0]  evt_stage;
    logic [23:0] evt_data;
    logic [2:0]  cur_stage;
    logic        train_done;
    logic        train_fail;
    logic [7:0]  fail_code;
    logic        evt_overflow;

    ddr_train_monitor #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phy_rst_n    (phy_rst_n),
        .stage_done   (stage_done),
        .error_status (error_status),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_type     (evt_type),
        .evt_stage    (evt_stage),
        .evt_data     (evt_data),
        .cur_stage    (cur_stage),
        .train_done   (train_done),
        .train_fail   (train_fail),
        .fail_code    (fail_code),
        .evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    int  pops  = 0;
    int  held  = 0;
    int  ready_mode = 0;   // 0 always ready, 1 random, 2 held off
    bit  exp_overflow = 0;
    ev_t exp_q[$];

    int  tt[NS];
    int  x_cur;
    bit  x_done, x_fail;
    int  x_code;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Consumer handshake
    initial begin
        evt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       evt_ready = 1'b1;
                1:       evt_ready = 1'($urandom_range(0, 1));
                default: evt_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted event is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            ev_t e;
            pops++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL evt_unexpected got type=%0d stage=%0d data=%0d exp none",
                         evt_type, evt_stage, evt_data);
            end else begin
                e = exp_q.pop_front();
                if ({evt_type, evt_stage, evt_data} !== e) begin
                    fails++;
                    $display("FAIL evt got type=%0d stage=%0d data=%0d exp type=%0d stage=%0d data=%0d",
                             evt_type, evt_stage, evt_data, e.typ, e.stg, e.data);
                end else begin
                    $display("[TB] evt type=%0d stage=%0d data=%0d ok", evt_type, evt_stage, evt_data);
                end
            end
        end
    end

    // Expected event entry; with the consumer held off only DEPTH events fit
    function automatic void add_exp(input logic [1:0] ty, input int stg, input int data);
        if (ready_mode == 2 && held >= DEPTH) begin
            exp_overflow = 1'b1;
        end else begin
            exp_q.push_back('{ty, 3'(stg), 24'(data)});
            if (ready_mode == 2) held++;
        end
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One training attempt. Cycle 0 is the first cycle phy_rst_n is high;
    // stage_done[k] is high from cycle tt[k]; error_status = v in cycle e only;
    // phy_rst_n is dropped in cycle a. INF means never.
    task automatic run_training(input int e, input int v, input int a);
        int prev, term, last, s;
        bit err_t, tmo_t;
        prev = 0; s = NS; err_t = 0; tmo_t = 0;
        add_exp(T_START, 0, 0);
        for (int k = 0; k < NS; k++) begin
            int ck, lim, when;
            ck  = (tt[k] > prev + 1) ? tt[k] : prev + 1;
            lim = INF;
`ifdef DDR_TRAIN_MON_TIMEOUT_EN
            lim = prev + TMO;
`endif
            when = min2(min2(a, e), min2(ck, lim));
            if (when >= INF || when == a) begin
                s = k; break;
            end else if (when == e) begin
                add_exp(T_ERR, k, v); err_t = 1; s = k; prev = e; break;
            end else if (when == ck) begin
                add_exp(T_STAGE, k, ck - prev); prev = ck;
            end else begin
                add_exp(T_TMO, k, TMO); tmo_t = 1; s = k; prev = lim; break;
            end
        end
        term = prev;
        if (e < INF && e > term) term = e;
        last = (a < INF) ? a : term + 3;
        if (a < INF) begin
            x_cur = 0; x_done = 0; x_fail = 0; x_code = 0;
        end else begin
            x_cur  = (s == NS) ? NS - 1 : s;
            x_done = (s == NS);
            x_fail = err_t || tmo_t;
            x_code = err_t ? v : 0;
        end
        for (int n = 0; n <= last; n++) begin
            phy_rst_n = (n < a);
            for (int k = 0; k < NS; k++) stage_done[k] = (tt[k] <= n);
            error_status = (n == e) ? 8'(v) : 8'h00;
            @(posedge clk);
            #1;
        end
        error_status = 8'h00;
    endtask

    task automatic drain_wait();
        int i;
        for (i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !evt_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_status();
        chk("cur_stage", cur_stage, x_cur);
        chk("train_done", train_done, x_done);
        chk("train_fail", train_fail, x_fail);
        chk("fail_code", fail_code, x_code);
    endtask

    task automatic phy_drop_check();
        phy_rst_n  = 1'b0;
        stage_done = '0;
        @(posedge clk);
        #1;
        chk("clr_cur_stage", cur_stage, 0);
        chk("clr_train_done", train_done, 0);
        chk("clr_train_fail", train_fail, 0);
        chk("clr_fail_code", fail_code, 0);
        chk("overflow_flag", evt_overflow, exp_overflow);
        @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input int e, input int v, input int a);
        run_training(e, v, a);
        drain_wait();
        check_status();
        phy_drop_check();
    endtask

    initial begin
        int pops0;
        rst_n = 1'b0; phy_rst_n = 1'b0; stage_done = '0; error_status = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_type", evt_type, 0);
        chk("rst_evt_stage", evt_stage, 0);
        chk("rst_evt_data", evt_data, 0);
        chk("rst_cur_stage", cur_stage, 0);
        chk("rst_train_done", train_done, 0);
        chk("rst_train_fail", train_fail, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_overflow", evt_overflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stages 100 cycles apart
        tt = '{100, 200, 300, 400, 500};
        run_and_check(INF, 0, INF);

        // Three done bits together
        tt = '{10, 10, 10, INF, INF};
        run_and_check(INF, 0, INF);

        // Error together with stage 2 completion
        tt = '{5, 10, 20, 50, 60};
        run_and_check(20, 8'h24, INF);

        // PHY reset in the middle of stage 3
        tt = '{5, 10, 15, 200, 300};
        run_and_check(INF, 0, 40);

`ifdef DDR_TRAIN_MON_TIMEOUT_EN
        // Stage 1 never completes
        tt = '{5, INF, INF, INF, INF};
        run_and_check(INF, 0, INF);
`endif

        // Randomized attempts with a randomly stalling consumer
        ready_mode = 1;
        for (int r = 0; r < 12; r++) begin
            int e, v, a;
            tt[0] = $urandom_range(1, 30);
            for (int k = 1; k < NS; k++) tt[k] = tt[k-1] + $urandom_range(0, 30);
            if ($urandom_range(0, 5) == 0) begin
                for (int k = $urandom_range(0, NS - 1); k < NS; k++) tt[k] = INF;
            end
            e = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : INF;
            v = $urandom_range(1, 255);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 150) : INF;
            run_and_check(e, v, a);
        end

        // Overflow: consumer held off while ten events are produced
        ready_mode = 2; evt_ready = 1'b0; held = 0; pops0 = pops;
        @(posedge clk);
        #1;
        tt = '{1, 1, 1, 1, 1};
        run_training(INF, 0, INF);
        check_status();
        phy_drop_check();
        tt = '{1, 1, 1, INF, INF};
        run_training(INF, 0, INF);
        check_status();
        phy_drop_check();
        chk("ovf_valid_held", evt_valid, 1);
        chk("ovf_sticky", evt_overflow, 1);
        ready_mode = 0; evt_ready = 1'b1;
        drain_wait();
        chk("ovf_drained_count", pops - pops0, DEPTH);

        // Chip reset with events pending discards them
        ready_mode = 2; evt_ready = 1'b0; held = 0;
        @(posedge clk);
        #1;
        tt = '{1, 2, INF, INF, INF};
        run_training(INF, 0, INF);
        chk("pend_valid", evt_valid, 1);
        rst_n = 1'b0; phy_rst_n = 1'b0; stage_done = '0;
        #1;
        chk("arst_evt_valid", evt_valid, 0);
        chk("arst_overflow", evt_overflow, 0);
        chk("arst_cur_stage", cur_stage, 0);
        chk("arst_train_fail", train_fail, 0);
        exp_q.delete(); exp_overflow = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; ready_mode = 0; evt_ready = 1'b1;
        @(posedge clk);
        #1;
        tt = '{3, 6, 9, 12, 15};
        run_and_check(INF, 0, INF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
